// File: rtl/bounce_emulator.sv
// Contact-bounce emulator: replays a clean level change as a lead phase, glitch pulses and a settle hold.
// Optional BOUNCE_EMU_LFSR_EN adds a pseudo-random extension to every gap.
module bounce_emulator #(
    parameter int          NUM_GLITCH = 2,
    parameter int          MIN_GAP    = 2,
    parameter int          GAP_W      = 3,
    parameter int          SETTLE_CYC = 4,
    parameter logic [7:0]  SEED       = 8'hA5
) (
    input  logic clk,
    input  logic rst,
    input  logic clean_in,
    output logic noisy_out,
    output logic busy,
    output logic burst_done
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        GLITCH_LO,
        GLITCH_HI,
        SETTLE
    } state_t;

    localparam logic [7:0] SEED_EFF   = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] MIN_M1     = 8'(MIN_GAP - 1);
    localparam logic [7:0] SETTLE_M1  = 8'(SETTLE_CYC - 1);
    localparam logic [3:0] LAST_G     = 4'(NUM_GLITCH - 1);
    localparam bit         HAS_GLITCH = (NUM_GLITCH != 0);

    if (NUM_GLITCH < 0 || NUM_GLITCH > 15 || MIN_GAP < 1 || MIN_GAP > 255 ||
        GAP_W < 1 || GAP_W > 7 || SETTLE_CYC < 1 || SETTLE_CYC > 255 ||
        SEED_EFF == 8'h00) begin : g_illegal_params
        $error("bounce_emulator: parameter out of range");
    end

    state_t     state;
    logic       level_q;
    logic       target;
    logic [7:0] cnt;
    logic [3:0] glitch_cnt;
    logic [7:0] gap_m1;
    logic       cnt_zero;

    assign cnt_zero = (cnt == 8'd0);

`ifdef BOUNCE_EMU_LFSR_EN
    logic [7:0] lfsr;
    logic       load_gap;

    // Every cycle that reloads cnt with a gap consumes one LFSR step.
    always_comb begin
        load_gap = 1'b0;
        case (state)
            IDLE:      load_gap = (clean_in != level_q);
            LEAD:      load_gap = cnt_zero && HAS_GLITCH;
            GLITCH_LO: load_gap = cnt_zero;
            GLITCH_HI: load_gap = cnt_zero && (glitch_cnt != LAST_G);
            default:   load_gap = 1'b0;
        endcase
    end

    assign gap_m1 = MIN_M1 + 8'(lfsr[GAP_W-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED_EFF;
        end else if (load_gap) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end
`else
    assign gap_m1 = MIN_M1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            level_q    <= 1'b0;
            target     <= 1'b0;
            noisy_out  <= 1'b0;
            busy       <= 1'b0;
            burst_done <= 1'b0;
            cnt        <= 8'd0;
            glitch_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    burst_done <= 1'b0;
                    busy       <= 1'b0;
                    noisy_out  <= level_q;
                    if (clean_in != level_q) begin
                        target     <= clean_in;
                        noisy_out  <= clean_in;
                        busy       <= 1'b1;
                        cnt        <= gap_m1;
                        glitch_cnt <= 4'd0;
                        state      <= LEAD;
                    end
                end
                LEAD: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 8'd1;
                    end else if (HAS_GLITCH) begin
                        noisy_out <= ~target;
                        cnt       <= gap_m1;
                        state     <= GLITCH_LO;
                    end else begin
                        cnt   <= SETTLE_M1;
                        state <= SETTLE;
                    end
                end
                GLITCH_LO: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        noisy_out <= target;
                        cnt       <= gap_m1;
                        state     <= GLITCH_HI;
                    end
                end
                GLITCH_HI: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 8'd1;
                    end else if (glitch_cnt == LAST_G) begin
                        cnt   <= SETTLE_M1;
                        state <= SETTLE;
                    end else begin
                        glitch_cnt <= glitch_cnt + 4'd1;
                        noisy_out  <= ~target;
                        cnt        <= gap_m1;
                        state      <= GLITCH_LO;
                    end
                end
                SETTLE: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        level_q    <= target;
                        busy       <= 1'b0;
                        burst_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bounce_emulator.md
BOUNCE_EMULATOR -- requirements
Module: bounce_emulator

Interface
REQ-001 SHALL have parameter NUM_GLITCH, default 2: glitch pulses per transition, legal 0..15.
REQ-002 SHALL have parameter MIN_GAP, default 2: base phase length in cycles, legal 1..255.
REQ-003 SHALL have parameter GAP_W, default 3: width of the random gap extension, legal 1..7.
REQ-004 SHALL have parameter SETTLE_CYC, default 4: post-bounce hold in cycles, legal 1..255.
REQ-005 SHALL have parameter SEED, default 8'hA5: LFSR reset value; a value of 0 is replaced by 8'h01.
REQ-006 SHALL have port clk, input, 1 bit: single clock, all state on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port clean_in, input, 1 bit: ideal level, synchronous to clk.
REQ-009 SHALL have port noisy_out, output, 1 bit: emulated bouncing contact, registered.
REQ-010 SHALL have port busy, output, 1 bit: high while a burst or settle is in progress.
REQ-011 SHALL have port burst_done, output, 1 bit: one-cycle pulse marking burst completion.

Function
REQ-012 SHALL implement the states IDLE, LEAD, GLITCH_LO, GLITCH_HI and SETTLE, plus an internal settled level, level_q.
REQ-013 In IDLE, SHALL hold noisy_out equal to level_q with busy low; when clean_in != level_q at a clock edge, SHALL latch target=clean_in, set noisy_out=target at that edge, and enter LEAD.
REQ-014 Latency SHALL be one edge from the sampled clean_in change to the first noisy_out change.
REQ-015 LEAD SHALL hold target for one gap; then, per glitch, GLITCH_LO SHALL drive ~target for one gap and GLITCH_HI SHALL drive target for one gap.
REQ-016 After glitch NUM_GLITCH, SHALL enter SETTLE and hold target for SETTLE_CYC cycles, then return to IDLE with level_q=target.
REQ-017 When NUM_GLITCH=0, LEAD SHALL go directly to SETTLE.
REQ-018 busy SHALL be high in every cycle that is not IDLE.
REQ-019 burst_done SHALL be high for exactly the first IDLE cycle after SETTLE.
REQ-020 Total busy length SHALL equal gap-sum + SETTLE_CYC; with fixed gaps this is MIN_GAP*(1+2*NUM_GLITCH)+SETTLE_CYC.
REQ-021 SHALL ignore clean_in while busy; in IDLE it SHALL re-compare clean_in, so a changed level starts a new burst immediately on the burst_done cycle and an unchanged level does nothing.
REQ-022 Gap counters SHALL be 8 bits and saturate-free; gap length SHALL never be 0.

Reset
REQ-023 On rst, SHALL asynchronously force state=IDLE, level_q=0, noisy_out=0, busy=0, burst_done=0, counters=0, and LFSR=SEED (or 8'h01 if SEED=0).
REQ-024 Reset asserted mid-burst SHALL abort the burst with no burst_done pulse.
REQ-025 After rst deasserts with clean_in=1, SHALL start a burst on the first edge.

Configuration
REQ-026 With BOUNCE_EMU_LFSR_EN defined, each gap SHALL be MIN_GAP + lfsr[GAP_W-1:0].
REQ-027 With BOUNCE_EMU_LFSR_EN defined, the LFSR SHALL be an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, stepping once each time a gap is loaded.
REQ-028 With BOUNCE_EMU_LFSR_EN undefined, every gap SHALL be exactly MIN_GAP and no LFSR logic SHALL exist.

Verification (defaults, macro undefined unless stated)
REQ-029 Reset, then clean_in 0->1 -> noisy_out over 14 cycles = 1,1,0,0,1,1,0,0,1,1,1,1,1,1; busy high 14 cycles; burst_done pulses on cycle 15.
REQ-030 After REQ-029 completes, clean_in 1->0 -> mirror sequence 0,0,1,1,0,0,1,1,0,0,0,0,0,0; level_q ends at 0.
REQ-031 clean_in toggles 1->0->1 within busy -> burst unaffected; no new burst when IDLE is reached with clean_in=1.
REQ-032 clean_in changes during burst and stays changed -> new burst starts on the burst_done cycle.
REQ-033 rst pulsed at cycle 5 of a burst -> noisy_out=0 and busy=0 immediately; no burst_done pulse.
REQ-034 BOUNCE_EMU_LFSR_EN defined, SEED=8'hA5 -> every gap in 2..9; identical sequence after each reset; busy length equals the sum of the logged gaps + 4.
